// File: rtl/rtc_pkg.sv
// Shared state encoding and constants for the RTC access controller.
// Pure declarations: no latency, no flow control.
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int         NBYTES        = 6;
    localparam logic [2:0] LAST_IDX      = 3'(NBYTES - 1);
    localparam logic [7:0] DEF_BASE_ADDR = 8'h21;

    function automatic logic [7:0] byte_of(input logic [8*NBYTES-1:0] word,
                                           input logic [2:0]          idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Free-running period counter; tick is high during the last cycle of each period.
// Combinational tick output, never stalls.
module rtc_tick_gen #(
    parameter int TICK_CYC = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_access_ctrl.sv
// Serialises 6-byte RTC reads (periodic or forced after a write) and user writes onto a byte bus.
// One request per byte, held until bus_done; one idle cycle between bytes; never preempts a transfer.
module rtc_access_ctrl
    import rtc_pkg::*;
#(
    parameter int         TICK_CYC  = 1_000_000,
    parameter logic [7:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        wr_go,
    input  logic [47:0] dato_user,
    input  logic        bus_done,
    input  logic [7:0]  bus_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    output logic [47:0] dato_rtc,
    output logic        dato_valid,
    output logic        busy
);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic        wr_pend_q;
    logic        rd_pend_q;
    logic [47:0] wr_shadow_q;
    logic [47:0] rd_shadow_q;
    logic [47:0] dato_rtc_q;
    logic        dato_valid_q;
    logic        bus_req_q;
    logic        bus_wr_q;
    logic [7:0]  bus_addr_q;
    logic [7:0]  bus_wdata_q;

    logic        tick;
    logic        wr_accept;
    logic        xfer_done;
    logic        last_byte;
    logic        is_write;

    rtc_tick_gen #(
        .TICK_CYC (TICK_CYC)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .tick (tick)
    );

    // The write shadow must not change under an in-flight write, so wr_go is dropped then too.
    assign wr_accept = wr_go && !wr_pend_q && (state_q != ST_WRITE);
    assign xfer_done = bus_req_q && bus_done;
    assign last_byte = (idx_q == LAST_IDX);
    assign is_write  = (state_q == ST_WRITE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_shadow_q  <= '0;
            rd_shadow_q  <= '0;
            dato_rtc_q   <= '0;
            dato_valid_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            dato_valid_q <= 1'b0;
            if (wr_accept) begin
                wr_pend_q   <= 1'b1;
                wr_shadow_q <= dato_user;
            end
            if (tick) begin
                rd_pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    idx_q <= '0;
                    // A tick landing on the read-start cycle merges into that read.
                    if (wr_pend_q) begin
                        state_q   <= ST_WRITE;
                        wr_pend_q <= 1'b0;
                    end else if (rd_pend_q) begin
                        state_q   <= ST_READ;
                        rd_pend_q <= 1'b0;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (xfer_done) begin
                        bus_req_q <= 1'b0;
                        if (!is_write) begin
                            rd_shadow_q[{idx_q, 3'b000} +: 8] <= bus_rdata;
                        end
                        if (last_byte) begin
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                            if (is_write) begin
                                rd_pend_q <= 1'b1;
                            end else begin
                                dato_rtc_q   <= {bus_rdata, rd_shadow_q[39:0]};
                                dato_valid_q <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else if (!bus_req_q) begin
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= is_write;
                        bus_addr_q  <= BASE_ADDR + {5'b00000, idx_q};
                        bus_wdata_q <= is_write ? byte_of(wr_shadow_q, idx_q) : 8'h00;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign dato_rtc   = dato_rtc_q;
    assign dato_valid = dato_valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_access_ctrl.sv
// Bench for rtc_access_ctrl: a byte-bus responder plus a transaction scoreboard of expected
// writes, read snapshots and pend-flag ordering, checked on every completed byte and every cycle.
module tb_rtc_access_ctrl;

    localparam logic [47:0] SNAP = 48'h363534333231;

    logic        clk = 1'b0;
    logic        clr;
    logic        wr_go;
    logic [47:0] dato_user;
    logic        bus_done;
    logic [7:0]  bus_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [47:0] dato_rtc;
    logic        dato_valid;
    logic        busy;

    rtc_access_ctrl #(
        .TICK_CYC  (16),
        .BASE_ADDR (8'h21)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wr_go      (wr_go),
        .dato_user  (dato_user),
        .bus_done   (bus_done),
        .bus_rdata  (bus_rdata),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .dato_rtc   (dato_rtc),
        .dato_valid (dato_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: accepted write payloads, expected snapshot, model pend flags.
    logic [47:0] wr_q[$];
    logic [47:0] cur_data;
    logic [47:0] rtc_exp;
    int          tcnt_m;
    bit          wr_pend_m, rd_pend_m, op_wr, valid_exp, busy_p, rise_due;
    int          bi;
    int          reads_done, writes_done;
    bit          req_p, done_p, wr_p;
    logic [7:0]  addr_p, wdata_p;
    int          rcnt;
    int          done_delay = 4;
    bit          stray_en   = 1'b0;

    initial begin
        bit tick_m, started, wp_old;
        bus_done = 1'b0; bus_rdata = 8'h00;
        tcnt_m = 0; wr_pend_m = 0; rd_pend_m = 0; op_wr = 0; bi = 0; busy_p = 0; rise_due = 0;
        rtc_exp = '0; cur_data = '0; reads_done = 0; writes_done = 0; rcnt = 0;
        req_p = 0; done_p = 0; wr_p = 0; addr_p = '0; wdata_p = '0;
        forever begin
            @(posedge clk); #1;
            valid_exp = 1'b0;
            if (clr) begin
                tcnt_m = 0; wr_pend_m = 0; rd_pend_m = 0; bi = 0; op_wr = 0; rise_due = 0;
                rtc_exp = '0;
                wr_q.delete();
                chk("clr_req", bus_req, 0);
                chk("clr_busy", busy, 0);
                chk("clr_valid", dato_valid, 0);
                chk("clr_rtc", dato_rtc, 0);
                chk("clr_bus", {bus_wr, bus_addr, bus_wdata}, 0);
            end else begin
                tick_m  = (tcnt_m == 15);
                tcnt_m  = tick_m ? 0 : tcnt_m + 1;
                started = busy && !busy_p;
                wp_old  = wr_pend_m;
                if (rise_due) chk("req_rise", bus_req, 1);
                rise_due = 1'b0;
                if (!busy_p) chk("idle_start", started, wr_pend_m || rd_pend_m);
                if (started) begin
                    chk("entry_req", bus_req, 0);
                    rise_due = 1'b1;
                    bi    = 0;
                    op_wr = wr_pend_m;
                    if (wr_pend_m) begin
                        wr_pend_m = 0;
                        if (wr_q.size() > 0) cur_data = wr_q.pop_front();
                    end else begin
                        rd_pend_m = 0;
                    end
                end
                if (wr_go && !wp_old && !(op_wr && busy_p)) begin
                    wr_pend_m = 1;
                    wr_q.push_back(dato_user);
                end
                if (tick_m && !(started && !op_wr)) rd_pend_m = 1;
                if (req_p && done_p) begin
                    chk("req_drop", bus_req, 0);
                    chk("xfer_wr", wr_p, op_wr);
                    chk("xfer_addr", addr_p, 8'h21 + bi);
                    if (op_wr) chk("xfer_wdata", wdata_p, cur_data[bi*8 +: 8]);
                    bi++;
                    if (bi == 6) begin
                        bi = 0;
                        chk("op_end_idle", busy, 0);
                        if (op_wr) begin
                            rd_pend_m = 1;
                            writes_done++;
                        end else begin
                            rtc_exp   = SNAP;
                            valid_exp = 1'b1;
                            reads_done++;
                        end
                    end else begin
                        rise_due = 1'b1;
                    end
                end else if (req_p && bus_req) begin
                    chk("bus_stable", {bus_wr, bus_addr, bus_wdata}, {wr_p, addr_p, wdata_p});
                end
                chk("dato_valid", dato_valid, valid_exp);
                chk("dato_rtc", dato_rtc, rtc_exp);
            end
            busy_p = busy;
            // Bus responder: done after the request has been visible for done_delay cycles.
            if (bus_req) rcnt++; else rcnt = 0;
            bus_done  = bus_req ? (rcnt >= done_delay) : stray_en;
            bus_rdata = bus_req ? bus_addr + 8'h10 : 8'hEE;
            req_p = bus_req; done_p = bus_done; wr_p = bus_wr; addr_p = bus_addr; wdata_p = bus_wdata;
        end
    end

    task automatic pulse_wr(input logic [47:0] d);
        dato_user = d;
        wr_go     = 1'b1;
        @(negedge clk);
        wr_go     = 1'b0;
    endtask

    task automatic wait_ops(input string tag, input int rd_tgt, input int wr_tgt, input int budget);
        int i = 0;
        while ((reads_done < rd_tgt || writes_done < wr_tgt) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, (reads_done >= rd_tgt) && (writes_done >= wr_tgt), 1);
    endtask

    task automatic wait_byte(input string tag, input bit want_wr, input int b, input int budget);
        int i = 0;
        while (!(busy && bus_req && op_wr == want_wr && bi == b) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, busy && bus_req && op_wr == want_wr && bi == b, 1);
    endtask

    task automatic do_clr(input int n);
        clr = 1'b1;
        repeat (n) @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int rd0, wr0, i;
        clr = 1'b1; wr_go = 1'b0; dato_user = '0;
        repeat (3) @(negedge clk);
        clr = 1'b0;

        // First periodic read after reset.
        wait_ops("first_read", 1, 0, 120);

        // Write on an idle bus, then forced read-back.
        do_clr(2);
        rd0 = reads_done;
        pulse_wr(48'h000000123456);
        wait_ops("idle_write", rd0 + 1, 1, 200);

        // Write requested during read byte 2; stray done pulses between transfers.
        stray_en = 1'b1;
        wait_byte("rd_byte2", 1'b0, 2, 200);
        rd0 = reads_done;
        pulse_wr(48'hCAFEF00DBEEF);
        wait_ops("write_after_read", rd0 + 2, 2, 300);

        // Tick and wr_go in the same cycle on an idle bus; a second wr_go mid-write is dropped.
        do_clr(1);
        i = 0;
        while (tcnt_m != 15 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("tick_align", tcnt_m, 15);
        rd0 = reads_done; wr0 = writes_done;
        pulse_wr(48'h0A0B0C0D0E0F);
        wait_byte("in_write", 1'b1, 1, 60);
        pulse_wr(48'hFFFFFFFFFFFF);
        wait_ops("tick_and_write", rd0 + 1, wr0 + 1, 200);
        chk("second_wr_dropped", wr_q.size(), 0);

        // Long stall on read byte 0: outputs held, ticks merge.
        wait_byte("stall_start", 1'b0, 0, 200);
        done_delay = 44;
        wait_byte("stall_end", 1'b0, 1, 120);
        done_delay = 4;
        rd0 = reads_done;
        wait_ops("after_stall", rd0 + 2, writes_done, 200);

        // Reset during read byte 3 aborts without a snapshot.
        wait_byte("rd_byte3", 1'b0, 3, 200);
        do_clr(1);
        rd0 = reads_done;
        wait_ops("after_abort", rd0 + 1, writes_done, 120);

        chk("wr_q_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
